spu_register_file_mp: RTL and testbench

Parametrised multi-port register file for the dual-issue SPU datapath (even and odd pipes). It provides NUM_RD registered read ports and NUM_WR write ports, with optional same-cycle write-to-read bypass and deterministic write-collision priority. A sequential clear engine zeroes the whole array after reset, and `ready` signals when clearing is done.

---
 rtl/spu_register_file_mp_pkg.sv | 17 +
 rtl/spu_register_file_mp_if.sv | 31 +++
 rtl/spu_register_file_mp_read_port.sv | 40 ++++
 rtl/spu_register_file_mp.sv | 120 ++++++++++++
 tb/tb_spu_register_file_mp.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_register_file_mp_pkg.sv
// Shared types and constants for the SPU multi-port register file.
// Imported by the interface, read port and top.
package spu_rf_pkg;

  localparam int SPU_DATA_W = 128;
  localparam int SPU_ADDR_W = 7;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spu_register_file_mp_if.sv
// Bundle of read/write port signals for the SPU register file.
// master drives addresses and enables, slave returns data and status.
interface spu_register_file_mp_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NUM_RD = 6,
  parameter int NUM_WR = 2
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     ready;
  logic                     wr_conflict;

  modport master (
    output rd_en, rd_addr,
    output wr_en, wr_addr, wr_data,
    input  rd_data, ready, wr_conflict
  );

  modport slave (
    input  rd_en, rd_addr,
    input  wr_en, wr_addr, wr_data,
    output rd_data, ready, wr_conflict
  );

endinterface

// File: rtl/spu_register_file_mp_read_port.sv
// One registered read port with optional write-first bypass.
// Later write ports override earlier ones on an address match.
module spu_rf_read_port #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     rdEn,
  input  logic [ADDR_W-1:0]        rdAddr,
  input  logic [DATA_W-1:0]        memData,
  input  logic [NUM_WR-1:0]        wrEn,
  input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
  input  logic [NUM_WR*DATA_W-1:0] wrData,
  output logic [DATA_W-1:0]        rdData
);

  logic [DATA_W-1:0] nxtData;

  always_comb begin
    nxtData = memData;
    if (BYPASS) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wrEn[j] && wrAddr[j*ADDR_W +: ADDR_W] == rdAddr)
          nxtData = wrData[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || hold)
      rdData <= '0;
    else if (rdEn)
      rdData <= nxtData;
  end

endmodule

// File: rtl/spu_register_file_mp.sv
// Multi-port register file for the dual-issue SPU datapath.
// Clears the array after reset, then serves NUM_RD reads and NUM_WR writes.
module spu_register_file_mp
  import spu_rf_pkg::*;
#(
  parameter int DATA_W        = SPU_DATA_W,
  parameter int ADDR_W        = SPU_ADDR_W,
  parameter int NUM_RD        = 6,
  parameter int NUM_WR        = 2,
  parameter int CLR_PER_CYCLE = 4,
  parameter bit BYPASS        = 1'b1
) (
  input logic clk,
  input logic reset,
  spu_register_file_mp_if.slave rf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = ptrWidth(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR =
    PTR_W'(DEPTH - CLR_PER_CYCLE);
  localparam logic [PTR_W-1:0] PTR_STEP =
    PTR_W'(CLR_PER_CYCLE);

  if (DEPTH % CLR_PER_CYCLE != 0) begin : gBadClr
    $error("DEPTH must be divisible by CLR_PER_CYCLE");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  rf_state_t         state;
  rf_state_t         nextState;
  logic [PTR_W-1:0]  clrPtr;
  logic              conflict;
  logic              active;
  logic [NUM_WR-1:0] wrEnQ;

  assign active = (state == RF_READY);
  assign wrEnQ  = active ? rf.wr_en : '0;

  always_comb begin
    nextState = state;
    unique case (state)
      RF_CLEAR: if (clrPtr == LAST_PTR) nextState = RF_READY;
      RF_READY: nextState = RF_READY;
      default:  nextState = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RF_CLEAR;
      clrPtr         <= '0;
      rf.ready       <= 1'b0;
      rf.wr_conflict <= 1'b0;
    end else begin
      state          <= nextState;
      rf.ready       <= (nextState == RF_READY);
      rf.wr_conflict <= active && conflict;
      if (state == RF_CLEAR)
        clrPtr <= clrPtr + PTR_STEP;
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (rf.wr_en[j] && rf.wr_en[k] &&
            rf.wr_addr[j*ADDR_W +: ADDR_W] ==
            rf.wr_addr[k*ADDR_W +: ADDR_W])
          conflict = 1'b1;
      end
    end
  end

  // Array has no reset; ascending port loop lets the highest port win.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == RF_CLEAR) begin
        for (int k = 0; k < CLR_PER_CYCLE; k++)
          mem[clrPtr + PTR_W'(k)] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (rf.wr_en[j])
            mem[rf.wr_addr[j*ADDR_W +: ADDR_W]] <=
              rf.wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] q;

    assign addr    = rf.rd_addr[i*ADDR_W +: ADDR_W];
    assign memData = mem[addr];
    assign rf.rd_data[i*DATA_W +: DATA_W] = q;

    spu_rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR),
      .BYPASS (BYPASS)
    ) uPort (
      .clk     (clk),
      .reset   (reset),
      .hold    (!active),
      .rdEn    (rf.rd_en[i]),
      .rdAddr  (addr),
      .memData (memData),
      .wrEn    (wrEnQ),
      .wrAddr  (rf.wr_addr),
      .wrData  (rf.wr_data),
      .rdData  (q)
    );
  end

endmodule

// File: tb/tb_spu_register_file_mp.sv
// Directed bench for spu_register_file_mp.
// Runs a bypass and a non-bypass instance on identical stimulus.
module tb_spu_register_file_mp;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int NR = 6;
  localparam int NW = 2;

  logic clk;
  logic reset;
  int   nRun;
  int   nFail;

  spu_register_file_mp_if #(DW, AW, NR, NW) rfA ();
  spu_register_file_mp_if #(DW, AW, NR, NW) rfB ();

  assign rfB.rd_en   = rfA.rd_en;
  assign rfB.rd_addr = rfA.rd_addr;
  assign rfB.wr_en   = rfA.wr_en;
  assign rfB.wr_addr = rfA.wr_addr;
  assign rfB.wr_data = rfA.wr_data;

  spu_register_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
    .CLR_PER_CYCLE(4), .BYPASS(1'b1)
  ) dut (.clk(clk), .reset(reset), .rf(rfA));

  spu_register_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
    .CLR_PER_CYCLE(4), .BYPASS(1'b0)
  ) dut0 (.clk(clk), .reset(reset), .rf(rfB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setRd(input int p, input logic en, input logic [AW-1:0] a);
    rfA.rd_en[p] = en;
    rfA.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic setWr(input int p, input logic en, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    rfA.wr_en[p] = en;
    rfA.wr_addr[p*AW +: AW] = a;
    rfA.wr_data[p*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rdA(input int p);
    return rfA.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rdB(input int p);
    return rfB.rd_data[p*DW +: DW];
  endfunction

  task automatic waitReady(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!rfA.ready && edges < 100);
  endtask

  task automatic test_reset();
    int e;
    reset = 1'b1;
    tick();
    tick();
    nRun++;
    if (rfA.ready !== 1'b0 || rfA.wr_conflict !== 1'b0 || rfA.rd_data !== '0) begin
      nFail++;
      $display("FAIL reset_state ready=%0b conf=%0b rd0=%h need 0,0,0",
               rfA.ready, rfA.wr_conflict, rdA(0));
    end
    reset = 1'b0;
    setRd(0, 1'b1, 7'd0);
    setRd(1, 1'b1, 7'd64);
    setRd(2, 1'b1, 7'd127);
    waitReady(e);
    nRun++;
    if (e !== 32) begin
      nFail++;
      $display("FAIL ready_latency got %0d edges need 32", e);
    end
    tick();
    for (int p = 0; p < 3; p++) begin
      nRun++;
      if (rdA(p) !== '0) begin
        nFail++;
        $display("FAIL clear_read port%0d got %h need 0", p, rdA(p));
      end
    end
  endtask

  task automatic test_write_read();
    rfA.rd_en = '0;
    setWr(0, 1'b1, 7'd2, 128'd54);
    tick();
    setWr(0, 1'b0, 7'd0, '0);
    setRd(0, 1'b1, 7'd2);
    tick();
    nRun++;
    if (rdA(0) !== 128'd54) begin
      nFail++;
      $display("FAIL write_read got %h need %h", rdA(0), 128'd54);
    end
    setRd(0, 1'b0, 7'd9);
    setWr(0, 1'b1, 7'd2, 128'd99);
    tick();
    setWr(0, 1'b0, 7'd0, '0);
    tick();
    nRun++;
    if (rdA(0) !== 128'd54) begin
      nFail++;
      $display("FAIL read_hold got %h need %h", rdA(0), 128'd54);
    end
  endtask

  task automatic test_bypass();
    setWr(1, 1'b1, 7'd5, 128'hAA);
    setRd(3, 1'b1, 7'd5);
    tick();
    setWr(1, 1'b0, 7'd0, '0);
    nRun++;
    if (rdA(3) !== 128'hAA) begin
      nFail++;
      $display("FAIL bypass_on got %h need %h", rdA(3), 128'hAA);
    end
    nRun++;
    if (rdB(3) !== '0) begin
      nFail++;
      $display("FAIL bypass_off got %h need 0", rdB(3));
    end
    tick();
    nRun++;
    if (rdB(3) !== 128'hAA) begin
      nFail++;
      $display("FAIL bypass_off_reread got %h need %h", rdB(3), 128'hAA);
    end
    setRd(3, 1'b0, 7'd0);
  endtask

  task automatic test_conflict();
    setWr(0, 1'b1, 7'd7, 128'd1);
    setWr(1, 1'b1, 7'd7, 128'd2);
    setRd(1, 1'b1, 7'd7);
    tick();
    setWr(0, 1'b0, 7'd0, '0);
    setWr(1, 1'b0, 7'd0, '0);
    nRun++;
    if (rfA.wr_conflict !== 1'b1 || rfB.wr_conflict !== 1'b1) begin
      nFail++;
      $display("FAIL conflict_pulse got %0b/%0b need 1/1",
               rfA.wr_conflict, rfB.wr_conflict);
    end
    nRun++;
    if (rdA(1) !== 128'd2) begin
      nFail++;
      $display("FAIL conflict_bypass got %h need 2", rdA(1));
    end
    tick();
    nRun++;
    if (rfA.wr_conflict !== 1'b0) begin
      nFail++;
      $display("FAIL conflict_clear got %0b need 0", rfA.wr_conflict);
    end
    nRun++;
    if (rdA(1) !== 128'd2 || rdB(1) !== 128'd2) begin
      nFail++;
      $display("FAIL conflict_winner got %h/%h need 2/2", rdA(1), rdB(1));
    end
    setRd(1, 1'b0, 7'd0);
  endtask

  task automatic test_reset_midclear();
    int e;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    nRun++;
    if (rfA.ready !== 1'b0) begin
      nFail++;
      $display("FAIL midclear_ready got %0b need 0", rfA.ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setWr(0, 1'b1, 7'd3, 128'd9);
    setWr(1, 1'b1, 7'd3, 128'd9);
    setRd(0, 1'b1, 7'd2);
    waitReady(e);
    setWr(0, 1'b0, 7'd0, '0);
    setWr(1, 1'b0, 7'd0, '0);
    nRun++;
    if (e !== 32) begin
      nFail++;
      $display("FAIL restart_latency got %0d edges need 32", e);
    end
    nRun++;
    if (rdA(0) !== '0 || rfA.wr_conflict !== 1'b0) begin
      nFail++;
      $display("FAIL clear_quiet rd=%h conf=%0b need 0,0", rdA(0), rfA.wr_conflict);
    end
    setRd(0, 1'b1, 7'd3);
    setRd(1, 1'b1, 7'd2);
    tick();
    nRun++;
    if (rdA(0) !== '0 || rdA(1) !== '0) begin
      nFail++;
      $display("FAIL discard_write got %h/%h need 0/0", rdA(0), rdA(1));
    end
    rfA.rd_en = '0;
  endtask

  task automatic test_all_ports();
    logic [DW-1:0] ones;
    ones = '1;
    setWr(0, 1'b1, 7'd127, ones);
    tick();
    setWr(0, 1'b0, 7'd0, '0);
    for (int p = 0; p < NR; p++) setRd(p, 1'b1, 7'd127);
    tick();
    for (int p = 0; p < NR; p++) begin
      nRun++;
      if (rdA(p) !== ones) begin
        nFail++;
        $display("FAIL all_ports port%0d got %h need all-ones", p, rdA(p));
      end
    end
    setRd(0, 1'b1, 7'd0);
    tick();
    nRun++;
    if (rdA(0) !== '0) begin
      nFail++;
      $display("FAIL wrap_addr0 got %h need 0", rdA(0));
    end
  endtask

  initial begin
    nRun  = 0;
    nFail = 0;
    reset = 1'b1;
    rfA.rd_en   = '0;
    rfA.rd_addr = '0;
    rfA.wr_en   = '0;
    rfA.wr_addr = '0;
    rfA.wr_data = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_reset_midclear();
    test_all_ports();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
